// File: rtl/adder.sv
// Ripple-carry adder built from a chain of 1-bit full-adder cells.
// Provides a combinational sum plus a one-cycle registered copy.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic [WIDTH-1:0] s_q,
  output logic             c_out_q,
  output logic             ovf_q
);

  // carry[i] feeds cell i; carry[WIDTH] leaves the MSB cell.
  logic [WIDTH:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : myadder
    full_adder fa (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (carry[i]),
      .s     (s[i]),
      .c_out (carry[i+1])
    );
  end

  assign c_out = carry[WIDTH];
  assign ovf   = carry[WIDTH-1] ^ carry[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      s_q     <= s;
      c_out_q <= c_out;
      ovf_q   <= ovf;
    end
  end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: vector table, exhaustive 4-bit sweep,
// reset corner cases and WIDTH=1 / WIDTH=16 random sweeps.

module tb_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  a4, b4, s4, s4_q;
  logic        c4, co4, ov4, co4_q, ov4_q;
  logic [0:0]  a1, b1, s1, s1_q;
  logic        c1, co1, ov1, co1_q, ov1_q;
  logic [15:0] a16, b16, s16, s16_q;
  logic        c16, co16, ov16, co16_q, ov16_q;

  adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .c_in(c4),
    .s(s4), .c_out(co4), .ovf(ov4), .s_q(s4_q), .c_out_q(co4_q), .ovf_q(ov4_q)
  );

  adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c_in(c1),
    .s(s1), .c_out(co1), .ovf(ov1), .s_q(s1_q), .c_out_q(co1_q), .ovf_q(ov1_q)
  );

  adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .c_in(c16),
    .s(s16), .c_out(co16), .ovf(ov16), .s_q(s16_q), .c_out_q(co16_q), .ovf_q(ov16_q)
  );

  typedef struct packed {
    logic [3:0] s;
    logic       co;
    logic       ov;
  } res4_t;

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  res4_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Two's-complement overflow from signed arithmetic, independent of carries.
  function automatic bit ovf_model(input int w, input longint unsigned x,
                                   input longint unsigned y, input bit c);
    longint sx, sy, t, lim;
    lim = longint'(1) << (w - 1);
    sx  = (x >= lim) ? longint'(x) - 2 * lim : longint'(x);
    sy  = (y >= lim) ? longint'(y) - 2 * lim : longint'(y);
    t   = sx + sy + longint'(c);
    return (t > lim - 1) || (t < -lim);
  endfunction

  // Assumes caller is just after a rising edge; drives, checks comb, then checks
  // the registered result one edge later through the scoreboard.
  task automatic apply4(input string name, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic [3:0] es, input logic eco,
                        input logic eov);
    res4_t r;
    a4 = a; b4 = b; c4 = c;
    #2;
    check({name, "_sum"}, {co4, s4}, {eco, es});
    check({name, "_ovf"}, ov4, eov);
    sb_q.push_back('{s: es, co: eco, ov: eov});
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 1, 0);
    end else begin
      r = sb_q.pop_front();
      check({name, "_reg"}, {co4_q, s4_q, ov4_q}, {r.co, r.s, r.ov});
    end
  endtask

  task automatic rand_sweep();
    longint unsigned sum;
    a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
    #1;
    sum = longint'(a1) + longint'(b1) + longint'(c1);
    check("w1_sum", {co1, s1}, sum);
    check("w1_ovf", ov1, ovf_model(1, a1, b1, c1));
    sum = longint'(a16) + longint'(b16) + longint'(c16);
    check("w16_sum", {co16, s16}, sum);
    check("w16_ovf", ov16, ovf_model(16, a16, b16, c16));
  endtask

  initial begin
    vec_t vecs[9];
    int unsigned sum;
    logic [8:0] n;

    vecs[0] = '{"zero",     4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0};
    vecs[1] = '{"probe",    4'd1,  4'd1,  1'b1, 4'd3,  1'b0, 1'b0};
    vecs[2] = '{"wrap_max", 4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
    vecs[3] = '{"wrap_one", 4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0};
    vecs[4] = '{"ovf_pos",  4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1};
    vecs[5] = '{"ovf_neg",  4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1};
    vecs[6] = '{"five_six", 4'd5,  4'd6,  1'b0, 4'd11, 1'b0, 1'b1};
    vecs[7] = '{"cancel",   4'd4,  4'd12, 1'b0, 4'd0,  1'b1, 1'b0};
    vecs[8] = '{"cin_only", 4'd0,  4'd0,  1'b1, 4'd1,  1'b0, 1'b0};

    // Reset with nonzero operands so reset must win over the load.
    rst = 1'b1;
    a4 = 4'd15; b4 = 4'd15; c4 = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    a16 = 16'hffff; b16 = 16'h1; c16 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_w4", {co4_q, s4_q, ov4_q}, 0);
    check("rst_w1", {co1_q, s1_q, ov1_q}, 0);
    check("rst_w16", {co16_q, s16_q, ov16_q}, 0);
    check("rst_comb_w4", {co4, s4}, 5'h1f);
    rst = 1'b0;

    foreach (vecs[i])
      apply4(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].co,
             vecs[i].ov);

    // Cell-level probe: 1+1+1 in bit 0 gives sum 1, carry 1.
    a4 = 4'd1; b4 = 4'd1; c4 = 1'b1;
    #2;
    check("cell0_s", dut4.myadder[0].fa.s, 1);
    check("cell0_cout", dut4.myadder[0].fa.c_out, 1);
    check("cell1_cin", dut4.myadder[1].fa.c_in, 1);
    check("cell3_cout", dut4.myadder[3].fa.c_out, 0);
    @(posedge clk); #1;

    // Exhaustive 4-bit sweep through the scoreboard.
    for (int k = 0; k < 512; k++) begin
      n   = 9'(k);
      sum = n[8:5] + n[4:1] + n[0];
      apply4("exh", n[8:5], n[4:1], n[0], sum[3:0], sum[4],
             ovf_model(4, n[8:5], n[4:1], n[0]));
    end

    // Mid-stream reset discards the in-flight result.
    sb_q.delete();
    a4 = 4'd5; b4 = 4'd6; c4 = 1'b0; rst = 1'b1;
    #2;
    check("mid_rst_comb_pre", s4, 11);
    @(posedge clk); #1;
    check("mid_rst_reg", {co4_q, s4_q, ov4_q}, 0);
    check("mid_rst_comb", s4, 11);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_reg", s4_q, 11);
    check("post_rst_ovf_q", ov4_q, 1);

    // Parameter sweep on WIDTH=1 and WIDTH=16.
    for (int k = 0; k < 200; k++) begin
      rand_sweep();
      @(posedge clk); #1;
    end
    a16 = 16'hffff; b16 = 16'h1; c16 = 1'b0;
    #1;
    check("w16_wrap_s", s16, 0);
    check("w16_wrap_cout", co16, 1);
    @(posedge clk); #1;
    check("w16_wrap_reg", {co16_q, s16_q}, 17'h10000);
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b1;
    #1;
    check("w1_cin_ovf", {co1, s1, ov1}, 3'b011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
